// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment scanner with refresh prescaler,
// per-frame input snapshot, hex/decimal decode, decimal points, blink and leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 64,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                      clk_m,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_en,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      blank_lz,
  input  logic                      hex_mode,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                seg,
  output logic                      frame_start
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [7:0]            SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Active-low a..g pattern for one nibble; 10..15 become a dash outside hex mode.
  function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hC0;
      4'h1:    pat = 8'hF9;
      4'h2:    pat = 8'hA4;
      4'h3:    pat = 8'hB0;
      4'h4:    pat = 8'h99;
      4'h5:    pat = 8'h92;
      4'h6:    pat = 8'h82;
      4'h7:    pat = 8'hF8;
      4'h8:    pat = 8'h80;
      4'h9:    pat = 8'h90;
      4'hA:    pat = hex ? 8'h88 : 8'hBF;
      4'hB:    pat = hex ? 8'h83 : 8'hBF;
      4'hC:    pat = hex ? 8'hC6 : 8'hBF;
      4'hD:    pat = hex ? 8'hA1 : 8'hBF;
      4'hE:    pat = hex ? 8'h86 : 8'hBF;
      default: pat = hex ? 8'h8E : 8'hBF;
    endcase
    return pat[6:0];
  endfunction

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lz;
  logic                    sh_hex;
  logic                    sh_phase;

  logic                    tick;
  logic                    fstart;
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_blink;
  logic                    src_lz;
  logic                    src_hex;
  logic                    src_phase;
  logic [3:0]              nib;
  logic                    upper_zero;
  logic                    lz_blank;
  logic                    blink_blank;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              seg_nxt;

  // Scan sequencing and slot rendering; a frame start renders straight from the live inputs.
  always_comb begin
    tick    = (div_cnt == DIV_LAST);
    idx_nxt = (idx == '0) ? IDX_LAST : idx - IDX_W'(1);
    fstart  = tick && (idx_nxt == IDX_LAST);

    src_digits = fstart ? digits   : sh_digits;
    src_dp     = fstart ? dp_en    : sh_dp;
    src_blink  = fstart ? blink_en : sh_blink;
    src_lz     = fstart ? blank_lz : sh_lz;
    src_hex    = fstart ? hex_mode : sh_hex;
    src_phase  = fstart ? blink_phase : sh_phase;

    nib = src_digits[4*int'(idx_nxt) +: 4];

    upper_zero = 1'b1;
    for (int j = 0; j < int'(NUM_DIGITS); j++) begin
      if ((j >= int'(idx_nxt)) && (src_digits[4*j +: 4] != 4'h0)) upper_zero = 1'b0;
    end
    lz_blank    = src_lz && upper_zero && (idx_nxt != '0);
    blink_blank = src_blink[idx_nxt] && src_phase;

    an_nxt          = '1;
    an_nxt[idx_nxt] = 1'b0;
    seg_nxt         = {~src_dp[idx_nxt], decode(nib, src_hex)};
    if (lz_blank) seg_nxt[6:0] = 7'h7F;
    if (blink_blank) begin
      an_nxt  = '1;
      seg_nxt = 8'hFF;
    end
  end

  // Prescaler, scan index and blink phase counter.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) idx <= idx_nxt;
      if (fstart) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

  // Frame snapshot; the phase is captured before its update so a frame blinks as one unit.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blink  <= '0;
      sh_lz     <= 1'b0;
      sh_hex    <= 1'b0;
      sh_phase  <= 1'b0;
    end else if (fstart) begin
      sh_digits <= digits;
      sh_dp     <= dp_en;
      sh_blink  <= blink_en;
      sh_lz     <= blank_lz;
      sh_hex    <= hex_mode;
      sh_phase  <= blink_phase;
    end
  end

  // Pin registers, updated only on ticks; polarity applied here.
  always_ff @(posedge clk_m or negedge rst_n) begin
    if (!rst_n) begin
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= fstart;
      if (tick) begin
        an  <= ACTIVE_LOW ? an_nxt  : ~an_nxt;
        seg <= ACTIVE_LOW ? seg_nxt : ~seg_nxt;
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for N common-anode digits. It replaces the fixed 4-digit scanner with a configurable digit count and a built-in refresh prescaler. It adds per-frame input snapshotting (no tearing), hex/decimal decode, per-digit decimal points and blink, and leading-zero suppression. It sits between the time/counter datapath and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 4, clk_m cycles per digit slot (>=1).
- BLINK_FRAMES, 64, completed frames per blink half-period (>=1).
- ACTIVE_LOW, 1, 1: an/seg active-low (board default); 0: both outputs inverted.
- clk_m  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  BCD/hex nibbles; nibble k = digits[4k+3:4k]; k = NUM_DIGITS-1 is leftmost.
- dp_en  in  NUM_DIGITS  decimal point on for digit k.
- blink_en  in  NUM_DIGITS  digit k blinks.
- blank_lz  in  1  suppress leading zeros.
- hex_mode  in  1  1: nibbles 10..15 shown as A b C d E F; 0: shown as dash.
- an  out  NUM_DIGITS  anode enables, an[k] drives digit k.
- seg  out  8  {dp,g,f,e,d,c,b,a}.
- frame_start  out  1  one-cycle pulse coincident with the leftmost digit of a new frame being driven.

## Operation
- Prescaler div_cnt counts 0..REFRESH_DIV-1. tick = (div_cnt == REFRESH_DIV-1). div_cnt wraps to 0 on tick.
- Scan index idx steps on each tick: NUM_DIGITS-1 down to 0, then back to NUM_DIGITS-1.
- Frame start: a tick where idx_next = NUM_DIGITS-1. On that edge all display inputs (digits, dp_en, blink_en, blank_lz, hex_mode) are captured into a shadow register. The new frame is rendered from the captured values, not the live inputs. Input changes mid-frame never appear until the next frame.
- Blink:
  - blink_cnt counts frame starts.
  - When BLINK_FRAMES frame starts have elapsed, blink_phase toggles and blink_cnt clears.
  - blink_phase therefore changes only at frame boundaries.
- Leading-zero suppression, with blank_lz=1 in the shadow:
  - Digit k is LZ-blank if its nibble and every nibble to its left are 0.
  - Digit 0 is never LZ-blank.
- Output rendering for digit idx_next, registered on the tick edge:
  - Blink-blanked (blink_en[k]=1 and blink_phase=1): all anodes inactive, all segments off (dp included).
  - LZ-blank: an[k] active; a–g off; dp per dp_en[k].
  - Normal: an[k] active, all others inactive; a–g decoded; dp lit iff dp_en[k].
- Decode table, active-low, dp off:
  - Digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - hex_mode=1: A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - hex_mode=0: nibbles 10..15 give dash=BF.
  - dp on clears bit 7.
- ACTIVE_LOW=0 bitwise-inverts both an and seg at the output registers.
- Exactly one anode is active at any time, except after reset and in blink-blanked slots, where none is active.

## Timing
- Reset (async assert, any cycle, including mid-frame):
  - an all inactive, seg all off (0xFF active-low), frame_start=0.
  - div_cnt=0, idx=0, blink_cnt=0, blink_phase=0, shadow=0.
- Release is synchronous to the next clk_m edges. The first tick occurs on the REFRESH_DIV-th rising edge after rst_n rises. That tick is a frame start: it drives the leftmost digit and pulses frame_start.
- Outputs are fully registered and change only on tick edges. Latency from frame-start capture to pins is 0 cycles: the captured value is rendered on the same edge.
- Live input to display: at most one frame, NUM_DIGITS*REFRESH_DIV cycles, plus wait for the next frame start.
- REFRESH_DIV=1: tick every cycle, idx advances every edge.
- NUM_DIGITS=1: every tick is a frame start, and frame_start is high on every tick.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Blink half-period = BLINK_FRAMES frames.

## Test plan
- Reset/first frame (N=4, DIV=4), digits=0x1234, release rst_n -> an=F, seg=FF for 3 edges; 4th edge an=0111, seg=F9, frame_start=1; then every 4 cycles an=1011/A4, 1101/B0, 1110/99, then wrap to 0111.
- Tear-free: change digits 0x1234->0x5678 while idx=2 -> rest of frame still shows 3,4; next frame shows 5,6,7,8.
- Decode: digits=0xABCF, hex_mode=1 -> 88,83,C6,8E; hex_mode=0 -> BF on all four; dp_en=0010 -> third slot seg=46 (C with dp) in hex mode.
- LZ: blank_lz=1, digits=0x0050 -> slots seg=FF,FF,92,C0 with an active each slot; digits=0x0000 -> only last slot shows C0.
- Blink (BLINK_FRAMES=2): blink_en=0001 -> digit 0 visible frames 1-2, an=F/seg=FF in its slot frames 3-4, visible 5-6; other digits unaffected.
- Async reset mid-frame (idx=1, div_cnt=2) -> an=F, seg=FF immediately without a clock edge; restart matches scenario 1.
